// File: rtl/sccomp_pkg.sv
// Shared definitions for the single-cycle MIPS-32 subset computer:
// opcode/funct encodings, ALU operation and next-PC select enums, and the
// default memory map.
package sccomp_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] DEF_DMEM_BASE = 32'h1001_0000;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2a;
    localparam logic [5:0] F_SLTU = 6'h2b;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_e;

    typedef enum logic [1:0] {
        NPC_SEQ, NPC_BR, NPC_JMP, NPC_JR
    } npc_sel_e;

endpackage

// File: rtl/sc_comp_dataflow_cpu.sv
// Single-cycle MIPS-32 subset core: decode, ALU, next-PC logic and the PC
// register. Memories live in the top level; this block sees the fetched
// instruction and a combinational data-memory read port.
module sc_comp_dataflow_cpu
    import sccomp_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt, dst, sa;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] rs_val, rt_val, imm_ext, alu_b, alu_res, wb_data;
    logic [31:0] pc4, br_tgt, j_tgt, npc;
    logic        use_imm, imm_zext, shift_sh, reg_we, wb_mem, wb_link;
    logic        is_beq, is_bne, is_j, is_jr, rs_eq_rt;
    alu_op_e     alu_op;
    npc_sel_e    npc_sel;

    assign opcode = inst[31:26];
    assign rs     = inst[25:21];
    assign rt     = inst[20:16];
    assign rd     = inst[15:11];
    assign shamt  = inst[10:6];
    assign funct  = inst[5:0];
    assign imm    = inst[15:0];
    assign target = inst[25:0];

    regfile cpu_ref (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (reg_we),
        .wa    (dst),
        .wd    (wb_data),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rs_val),
        .rd2   (rt_val)
    );

    // Instruction decode; unknown opcodes/functs fall through as NOPs.
    always_comb begin
        alu_op   = ALU_ADD;
        use_imm  = 1'b0;
        imm_zext = 1'b0;
        shift_sh = 1'b0;
        reg_we   = 1'b0;
        dst      = rd;
        wb_mem   = 1'b0;
        wb_link  = 1'b0;
        mem_we   = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        is_jr    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_we = 1'b1;
                case (funct)
                    F_ADD, F_ADDU: alu_op = ALU_ADD;
                    F_SUB, F_SUBU: alu_op = ALU_SUB;
                    F_AND:  alu_op = ALU_AND;
                    F_OR:   alu_op = ALU_OR;
                    F_XOR:  alu_op = ALU_XOR;
                    F_NOR:  alu_op = ALU_NOR;
                    F_SLT:  alu_op = ALU_SLT;
                    F_SLTU: alu_op = ALU_SLTU;
                    F_SLLV: alu_op = ALU_SLL;
                    F_SRLV: alu_op = ALU_SRL;
                    F_SRAV: alu_op = ALU_SRA;
                    F_SLL:  begin alu_op = ALU_SLL; shift_sh = 1'b1; end
                    F_SRL:  begin alu_op = ALU_SRL; shift_sh = 1'b1; end
                    F_SRA:  begin alu_op = ALU_SRA; shift_sh = 1'b1; end
                    F_JR:   begin reg_we = 1'b0; is_jr = 1'b1; end
                    default: reg_we = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin use_imm = 1'b1; reg_we = 1'b1; dst = rt; end
            OP_SLTI:  begin alu_op = ALU_SLT;  use_imm = 1'b1; reg_we = 1'b1; dst = rt; end
            OP_SLTIU: begin alu_op = ALU_SLTU; use_imm = 1'b1; reg_we = 1'b1; dst = rt; end
            OP_ANDI:  begin alu_op = ALU_AND; use_imm = 1'b1; imm_zext = 1'b1; reg_we = 1'b1; dst = rt; end
            OP_ORI:   begin alu_op = ALU_OR;  use_imm = 1'b1; imm_zext = 1'b1; reg_we = 1'b1; dst = rt; end
            OP_XORI:  begin alu_op = ALU_XOR; use_imm = 1'b1; imm_zext = 1'b1; reg_we = 1'b1; dst = rt; end
            OP_LUI:   begin alu_op = ALU_LUI; use_imm = 1'b1; reg_we = 1'b1; dst = rt; end
            OP_LW:    begin use_imm = 1'b1; reg_we = 1'b1; dst = rt; wb_mem = 1'b1; end
            OP_SW:    begin use_imm = 1'b1; mem_we = 1'b1; end
            OP_BEQ:   begin alu_op = ALU_SUB; is_beq = 1'b1; end
            OP_BNE:   begin alu_op = ALU_SUB; is_bne = 1'b1; end
            OP_J:     is_j = 1'b1;
            OP_JAL:   begin is_j = 1'b1; reg_we = 1'b1; dst = 5'd31; wb_link = 1'b1; end
            default:  ;
        endcase
    end

    assign imm_ext = imm_zext ? {16'h0, imm} : {{16{imm[15]}}, imm};
    assign alu_b   = use_imm ? imm_ext : rt_val;
    assign sa      = shift_sh ? shamt : rs_val[4:0];

    // ALU; shifts always operate on rt, its result doubles as the memory address.
    always_comb begin
        alu_res = 32'h0;
        case (alu_op)
            ALU_ADD:  alu_res = rs_val + alu_b;
            ALU_SUB:  alu_res = rs_val - alu_b;
            ALU_AND:  alu_res = rs_val & alu_b;
            ALU_OR:   alu_res = rs_val | alu_b;
            ALU_XOR:  alu_res = rs_val ^ alu_b;
            ALU_NOR:  alu_res = ~(rs_val | alu_b);
            ALU_SLT:  alu_res = {31'h0, $signed(rs_val) < $signed(alu_b)};
            ALU_SLTU: alu_res = {31'h0, rs_val < alu_b};
            ALU_SLL:  alu_res = rt_val << sa;
            ALU_SRL:  alu_res = rt_val >> sa;
            ALU_SRA:  alu_res = $signed(rt_val) >>> sa;
            ALU_LUI:  alu_res = {imm, 16'h0};
            default:  alu_res = 32'h0;
        endcase
    end

    assign addr      = alu_res;
    assign mem_wdata = rt_val;
    assign pc4       = pc + 32'd4;
    assign wb_data   = wb_link ? pc4 : (wb_mem ? mem_rdata : alu_res);
    assign rs_eq_rt  = (rs_val == rt_val);
    assign br_tgt    = pc4 + ({{16{imm[15]}}, imm} << 2);
    assign j_tgt     = {pc4[31:28], target, 2'b00};

    // Next-PC selection: jr beats j/jal beats a taken branch beats pc+4.
    always_comb begin
        npc_sel = NPC_SEQ;
        if (is_jr)                                          npc_sel = NPC_JR;
        else if (is_j)                                      npc_sel = NPC_JMP;
        else if ((is_beq && rs_eq_rt) || (is_bne && !rs_eq_rt)) npc_sel = NPC_BR;
        case (npc_sel)
            NPC_JR:  npc = rs_val;
            NPC_JMP: npc = j_tgt;
            NPC_BR:  npc = br_tgt;
            default: npc = pc4;
        endcase
    end

    // PC register; reset forces the fetch address back to RESET_PC at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= RESET_PC;
        else        pc <= npc;
    end

endmodule

// File: rtl/sc_comp_dataflow_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port. $0 reads as zero and swallows writes. Asynchronous active-low reset
// clears every register.
module regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] array_reg [0:31];

    // Write port; a read in the same cycle still sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) array_reg[i] <= 32'h0;
        end else if (we && (wa != 5'd0)) begin
            array_reg[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'h0 : array_reg[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'h0 : array_reg[ra2];

endmodule

// File: rtl/sc_comp_dataflow.sv
// Single-cycle MIPS-32 subset computer: core (instance sccpu) plus
// instruction ROM and word-addressed data RAM. Optional macro
// SCCOMP_TRACE_EN adds a per-falling-edge register dump; hardware is
// unchanged either way. ROM contents are loaded by the enclosing environment.
module sc_comp_dataflow
    import sccomp_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter int          IMEM_WORDS = 1024,
    parameter int          DMEM_WORDS = 1024,
    parameter logic [31:0] DMEM_BASE  = DEF_DMEM_BASE,
    parameter string       IMEM_FILE  = "imem.hex"
) (
    input  logic        clk_in,
    input  logic        reset,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] addr
);

    localparam int IW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam int DW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    logic [31:0] rom [0:IMEM_WORDS-1];
    logic [31:0] ram [0:DMEM_WORDS-1];
    logic [31:0] im_off, dm_off, dmem_rdata, dmem_wdata;
    logic        dmem_we, dm_hit;

    // Word offsets from each region base; anything past the end reads 0.
    assign im_off     = (pc - RESET_PC) >> 2;
    assign dm_off     = (addr - DMEM_BASE) >> 2;
    assign inst       = (im_off < IMEM_WORDS) ? rom[im_off[IW-1:0]] : 32'h0;
    assign dm_hit     = (dm_off < DMEM_WORDS);
    assign dmem_rdata = dm_hit ? ram[dm_off[DW-1:0]] : 32'h0;

    sc_comp_dataflow_cpu #(
        .RESET_PC (RESET_PC)
    ) sccpu (
        .clk       (clk_in),
        .rst_n     (reset),
        .inst      (inst),
        .pc        (pc),
        .addr      (addr),
        .mem_we    (dmem_we),
        .mem_wdata (dmem_wdata),
        .mem_rdata (dmem_rdata)
    );

    // Data RAM write; not cleared by reset, but a store is dropped while reset is held.
    always_ff @(posedge clk_in) begin
        if (reset && dmem_we && dm_hit) ram[dm_off[DW-1:0]] <= dmem_wdata;
    end

`ifdef SCCOMP_TRACE_EN
    // Golden-trace dump of architectural state on every falling edge.
    always @(negedge clk_in) begin
        $display("pc: %h", pc);
        $display("instr: %h", inst);
        for (int i = 0; i < 32; i++)
            $display("regfile%0d: %h", i, sccpu.cpu_ref.array_reg[i]);
    end
`endif

endmodule

// File: tb/tb_sc_comp_dataflow.sv
// Self-checking bench for sc_comp_dataflow: a directed program from the
// test plan, then random programs, all compared every cycle against an
// instruction-level reference model kept here.
module tb_sc_comp_dataflow;

    localparam logic [31:0] RPC = 32'h0040_0000;
    localparam logic [31:0] DB  = 32'h1001_0000;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b0;
    logic [31:0] inst, pc, addr;

    sc_comp_dataflow #(
        .RESET_PC   (RPC),
        .IMEM_WORDS (1024),
        .DMEM_WORDS (1024),
        .DMEM_BASE  (DB),
        .IMEM_FILE  ("")
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .inst   (inst),
        .pc     (pc),
        .addr   (addr)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    logic [31:0] img    [0:1023];
    logic [31:0] m_reg  [0:31];
    logic [31:0] m_dmem [0:1023];
    logic [31:0] m_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic load_rom();
        for (int i = 0; i < 1024; i++) dut.rom[i] = img[i];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        m_pc = RPC;
    endtask

    // Executes one instruction of the model; reports the data address for lw/sw.
    task automatic m_step(output bit is_mem, output logic [31:0] ea);
        logic [31:0] w, a, b, se, ze, val, npc, off, idx;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh;
        int          wr;
        idx = (m_pc - RPC) >> 2;
        w   = (idx < 1024) ? img[idx[9:0]] : 32'h0;
        op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; sh = w[10:6]; fn = w[5:0];
        se = {{16{w[15]}}, w[15:0]};
        ze = {16'h0, w[15:0]};
        a = m_reg[rs]; b = m_reg[rt];
        npc = m_pc + 4; wr = -1; val = 0; is_mem = 0; ea = a + se;
        case (op)
            6'h00: case (fn)
                6'h20, 6'h21: begin wr = rd; val = a + b; end
                6'h22, 6'h23: begin wr = rd; val = a - b; end
                6'h24: begin wr = rd; val = a & b; end
                6'h25: begin wr = rd; val = a | b; end
                6'h26: begin wr = rd; val = a ^ b; end
                6'h27: begin wr = rd; val = ~(a | b); end
                6'h2a: begin wr = rd; val = ($signed(a) < $signed(b)) ? 1 : 0; end
                6'h2b: begin wr = rd; val = (a < b) ? 1 : 0; end
                6'h04: begin wr = rd; val = b << a[4:0]; end
                6'h06: begin wr = rd; val = b >> a[4:0]; end
                6'h07: begin wr = rd; val = $signed(b) >>> a[4:0]; end
                6'h00: begin wr = rd; val = b << sh; end
                6'h02: begin wr = rd; val = b >> sh; end
                6'h03: begin wr = rd; val = $signed(b) >>> sh; end
                6'h08: npc = a;
                default: ;
            endcase
            6'h08, 6'h09: begin wr = rt; val = a + se; end
            6'h0a: begin wr = rt; val = ($signed(a) < $signed(se)) ? 1 : 0; end
            6'h0b: begin wr = rt; val = (a < se) ? 1 : 0; end
            6'h0c: begin wr = rt; val = a & ze; end
            6'h0d: begin wr = rt; val = a | ze; end
            6'h0e: begin wr = rt; val = a ^ ze; end
            6'h0f: begin wr = rt; val = {w[15:0], 16'h0}; end
            6'h23: begin
                is_mem = 1; off = (ea - DB) >> 2; wr = rt;
                val = (off < 1024) ? m_dmem[off[9:0]] : 32'h0;
            end
            6'h2b: begin
                is_mem = 1; off = (ea - DB) >> 2;
                if (off < 1024) m_dmem[off[9:0]] = b;
            end
            6'h04: if (a == b) npc = m_pc + 4 + (se << 2);
            6'h05: if (a != b) npc = m_pc + 4 + (se << 2);
            6'h02: npc = {npc[31:28], w[25:0], 2'b00};
            6'h03: begin npc = {npc[31:28], w[25:0], 2'b00}; wr = 31; val = m_pc + 4; end
            default: ;
        endcase
        if (wr > 0) m_reg[wr] = val;
        m_pc = npc;
    endtask

    task automatic cmp_state(input string ph);
        logic [31:0] idx;
        idx = (m_pc - RPC) >> 2;
        chk({ph, "_pc"}, pc, m_pc);
        chk({ph, "_inst"}, inst, (idx < 1024) ? img[idx[9:0]] : 32'h0);
        for (int i = 0; i < 32; i++)
            chk($sformatf("%s_r%0d", ph, i), dut.sccpu.cpu_ref.array_reg[i], m_reg[i]);
    endtask

    // One cycle: compare state, advance model, check lw/sw address, wait an edge.
    task automatic cycle(input string ph);
        bit          mem;
        logic [31:0] ea;
        cmp_state(ph);
        m_step(mem, ea);
        if (mem) chk({ph, "_addr"}, addr, ea);
        @(negedge clk_in);
    endtask

    task automatic release_reset();
        @(posedge clk_in);
        #1 reset = 1'b1;
        @(negedge clk_in);
    endtask

    logic [5:0] rfn [0:16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2a, 6'h2b, 6'h04, 6'h06, 6'h07, 6'h00, 6'h02, 6'h03, 6'h01};
    logic [5:0] iop [0:7]  = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f};

    function automatic logic [4:0] rdst();
        logic [4:0] d;
        d = 5'($urandom_range(0, 31));
        return (d == 5'd1) ? 5'd2 : d;
    endfunction

    // Random program: $1 holds the DMEM base, 8 words are pre-stored, branches go forward only.
    task automatic gen_prog(input int n);
        logic [4:0] s;
        for (int i = 0; i < 1024; i++) img[i] = 32'h0;
        img[0] = enc_i(6'h0f, 0, 1, 16'h1001);
        for (int i = 0; i < 8; i++) img[1 + i] = enc_i(6'h2b, 1, 0, 16'(4 * i));
        for (int i = 9; i < n; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: img[i] = enc_r(rfn[$urandom_range(0, 16)], 5'($urandom_range(0, 31)),
                                        5'($urandom_range(0, 31)), rdst(), 5'($urandom_range(0, 31)));
                3, 4, 5: img[i] = enc_i(iop[$urandom_range(0, 7)], 5'($urandom_range(0, 31)),
                                        rdst(), 16'($urandom));
                6: img[i] = enc_i(6'h23, 1, rdst(), 16'($urandom_range(0, 31)));
                7: img[i] = enc_i(6'h2b, 1, 5'($urandom_range(0, 31)), 16'($urandom_range(0, 31)));
                8: begin
                    s = 5'($urandom_range(0, 31));
                    img[i] = enc_i($urandom_range(0, 1) ? 6'h04 : 6'h05, s,
                                   $urandom_range(0, 1) ? s : 5'($urandom_range(0, 31)),
                                   16'($urandom_range(0, 3)));
                end
                default: img[i] = {$urandom_range(0, 1) ? 6'h3f : 6'h11, 26'($urandom)};
            endcase
        end
    endtask

    task automatic run_prog(input int n, input int budget, input string ph);
        int steps = 0;
        while (((m_pc - RPC) >> 2) < n && steps < budget) begin
            cycle(ph);
            steps++;
        end
        chk({ph, "_done"}, 32'(steps < budget), 32'd1);
        cmp_state(ph);
    endtask

    logic [31:0] prev_pc;

    initial begin
        for (int i = 0; i < 1024; i++) m_dmem[i] = 32'h0;
        for (int i = 0; i < 1024; i++) img[i] = 32'h0;
        img[0]  = enc_i(6'h0f, 0, 1, 16'h1001);
        img[1]  = enc_i(6'h0d, 1, 1, 16'h0004);
        img[2]  = enc_i(6'h09, 0, 2, 16'hffff);
        img[3]  = enc_r(6'h02, 0, 2, 3, 28);
        img[4]  = enc_r(6'h03, 0, 2, 4, 28);
        img[5]  = enc_r(6'h2b, 0, 2, 5, 0);
        img[6]  = enc_i(6'h2b, 1, 2, 16'h0000);
        img[7]  = enc_i(6'h23, 1, 6, 16'h0000);
        img[8]  = enc_i(6'h04, 0, 0, 16'h0002);
        img[9]  = enc_i(6'h09, 0, 7, 16'h0001);
        img[10] = enc_i(6'h09, 0, 7, 16'h0002);
        img[11] = enc_i(6'h05, 0, 0, 16'h0005);
        img[12] = enc_j(6'h03, 26'h010000f);
        img[13] = enc_i(6'h09, 0, 8, 16'h0055);
        img[14] = enc_j(6'h02, 26'h0100011);
        img[15] = enc_i(6'h09, 0, 0, 16'h0005);
        img[16] = enc_r(6'h08, 31, 0, 0, 0);
        img[17] = enc_i(6'h09, 0, 9, 16'h0077);
        #1 load_rom();
        model_reset();
        @(posedge clk_in);
        release_reset();

        // Directed program with explicit control-flow and result checks.
        chk("rst_pc", pc, 32'h0040_0000);
        prev_pc = 32'h0;
        for (int s = 0; s < 16; s++) begin
            if (prev_pc == 32'h0040_0020) chk("beq_taken", pc, 32'h0040_002c);
            if (prev_pc == 32'h0040_002c) chk("bne_not_taken", pc, 32'h0040_0030);
            if (prev_pc == 32'h0040_0030) chk("jal_tgt", pc, 32'h0040_003c);
            if (prev_pc == 32'h0040_0040) chk("jr_ret", pc, 32'h0040_0034);
            if (pc == 32'h0040_0018 || pc == 32'h0040_001c) chk("lwsw_addr", addr, 32'h1001_0004);
            if (s == 1) chk("second_pc", pc, 32'h0040_0004);
            prev_pc = pc;
            cycle("dir");
        end
        cmp_state("dir");
        chk("r1_lui_ori", dut.sccpu.cpu_ref.array_reg[1], 32'h1001_0004);
        chk("r2_addiu", dut.sccpu.cpu_ref.array_reg[2], 32'hffff_ffff);
        chk("r3_srl", dut.sccpu.cpu_ref.array_reg[3], 32'h0000_000f);
        chk("r4_sra", dut.sccpu.cpu_ref.array_reg[4], 32'hffff_ffff);
        chk("r5_sltu", dut.sccpu.cpu_ref.array_reg[5], 32'h0000_0001);
        chk("r6_lw", dut.sccpu.cpu_ref.array_reg[6], 32'hffff_ffff);
        chk("r7_skipped", dut.sccpu.cpu_ref.array_reg[7], 32'h0);
        chk("r8_after_ret", dut.sccpu.cpu_ref.array_reg[8], 32'h0000_0055);
        chk("r9_after_j", dut.sccpu.cpu_ref.array_reg[9], 32'h0000_0077);
        chk("r31_link", dut.sccpu.cpu_ref.array_reg[31], 32'h0040_0034);
        chk("r0_const", dut.sccpu.cpu_ref.array_reg[0], 32'h0);
        chk("end_pc", pc, 32'h0040_0048);

        // Random program, interrupted by an asynchronous reset mid-run.
        reset = 1'b0;
        gen_prog(160);
        load_rom();
        model_reset();
        release_reset();
        for (int s = 0; s < 60; s++) cycle("rnd1");
        #2 reset = 1'b0;
        #1;
        chk("async_rst_pc", pc, RPC);
        for (int i = 0; i < 32; i++)
            chk($sformatf("async_rst_r%0d", i), dut.sccpu.cpu_ref.array_reg[i], 32'h0);

        // Fresh random program run to completion.
        gen_prog(200);
        load_rom();
        model_reset();
        release_reset();
        run_prog(200, 260, "rnd2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sc_comp_dataflow.md
# sc_comp_dataflow

Single-cycle, non-pipelined MIPS-32 subset computer: CPU core plus instruction ROM and data RAM behind one top level. Every instruction fetches, executes and retires in exactly one clock. Used as the simulation top for register-trace comparison against a MARS-style golden trace.

## Interface
- `RESET_PC`, default 32'h0040_0000: PC value after reset.
- `IMEM_WORDS`, default 1024: instruction ROM depth in words.
- `DMEM_WORDS`, default 1024: data RAM depth in words.
- `DMEM_BASE`, default 32'h1001_0000: byte address mapped to DMEM word 0.
- `IMEM_FILE`, default "imem.hex": `$readmemh` image for the ROM.
- `clk_in` (input, 1): single clock; all state updates on the rising edge.
- `reset` (input, 1): asynchronous, active-low.
- `inst` (output, 32): instruction currently addressed by `pc`.
- `pc` (output, 32): current program counter.
- `addr` (output, 32): data memory byte address, i.e. the ALU result.

## Operation
- Register file: 32×32, register 0 reads as 0 and ignores writes; 2 asynchronous reads, 1 synchronous write.
- IMEM index = (pc − RESET_PC)[..:2]. DMEM index = (addr − DMEM_BASE)[..:2]. Out-of-range reads return 0; out-of-range writes are dropped.
- R-type instructions: addu, subu, and, or, xor, nor, slt, sltu, sllv, srlv, srav, and jr.
  - Shift instructions sll, srl, sra take their shift amount from shamt.
  - `add` and `sub` behave as `addu` and `subu`; there is no overflow trap.
- I-type instructions: addiu, addi (same as addiu), andi, ori, xori, lui, slti, sltiu, lw, sw, beq, bne.
  - andi, ori and xori zero-extend the immediate; all other I-type instructions sign-extend it.
- J-type instructions: j and jal.
  - jal writes pc+4 to $31.
  - The jump target is {pc+4[31:28], target, 2'b00}.
- Branches: the target is pc+4 + (sext(imm)<<2). There is no delay slot.
- Next-PC priority: jr, then j/jal, then a taken branch, then pc+4.
- lw and sw are word-only. The low 2 address bits are ignored.
- Unknown opcodes and functs execute as NOPs: no register or memory write, pc+4.

## Timing
- On reset assertion, asynchronously:
  - `pc` = RESET_PC.
  - All 32 registers = 0.
  - DMEM is not cleared.
- Reset outputs: `inst` = ROM[0]; `addr` follows combinationally from that instruction.
- First fetch occurs at RESET_PC on the first rising edge after reset is released.
- Latency: 1 cycle per instruction.
  - Register, DMEM and PC writes all commit on the same rising edge.
  - Results are visible at the following falling edge.
- Reads are combinational. A lw's destination value appears at the next edge.
- Reading a register in the cycle it is being written returns the old value.
- Reset asserted mid-cycle aborts the in-flight write; no partial commit.

## Configuration
- `SCCOMP_TRACE_EN`
  - Defined: on each falling edge of `clk_in`, `$display` prints pc, inst and registers 0–31 in hex, one per line, formatted "regfileN: %h".
  - Undefined: no display logic is compiled; the hardware is identical in both cases.

## Structure
- Shared package `sccomp_pkg` holds:
  - Opcode and funct localparams.
  - ALU operation enum.
  - Next-PC select enum.
  - RESET_PC and DMEM_BASE defaults.
- Fixed hierarchy, which the verification benches probe:
  - Top instantiates the CPU as `sccpu`.
  - `sccpu` instantiates the register file as `cpu_ref`.
  - The register storage array is named `array_reg[0:31]`.
- One natural sub-module: `regfile` (instance `cpu_ref`). ALU, decoder, IMEM and DMEM remain in the CPU or top level.

## Test plan
- Reset low, then high: the first falling edge shows pc=00400000 and every array_reg=0; the next edge shows pc=00400004.
- `lui $1,0x1001` then `ori $1,$1,0x0004` → array_reg[1]=10010004.
- `addiu $2,$0,-1` → array_reg[2]=ffffffff.
  - Then `srl $3,$2,28` → 0000000f.
  - Then `sra $4,$2,28` → ffffffff.
  - Then `sltu $5,$0,$2` → 1.
- `sw $2,0($1)` then `lw $6,0($1)` → array_reg[6]=ffffffff and addr=10010004 during both instructions.
- `beq $0,$0,+2` at 00400020 → next pc=0040002c.
  - `bne $0,$0,…` is not taken (pc+4).
  - `jal` at pc P → $31=P+4.
  - `jr $31` then returns to P+4.
- `addiu $0,$0,5` → array_reg[0] stays 0.
- Asserting reset mid-program → pc=00400000 and all registers 0 immediately, without waiting for a clock edge.
